// File: rtl/rgb_led_seq_pkg.sv
// Shared types and constants for the RGB LED step sequencer.
package rgb_led_seq_pkg;

  localparam int CH_R      = 0;
  localparam int CH_G      = 1;
  localparam int CH_B      = 2;
  localparam int SEQ_LEN_W = 32;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} seq_state_t;

  typedef struct packed {
    logic [2:0] mode;
    logic [2:0] enable;
    logic [2:0] hold;
  } seq_ctrl_t;

  typedef struct packed {
    logic [SEQ_LEN_W-1:0] len;
    seq_ctrl_t            ctrl;
  } seq_step_t;

endpackage

// File: rtl/rgb_led_seq_table.sv
// Step table: simple dual-port RAM, registered read-first output, no reset on contents.
module rgb_led_seq_table #(
  parameter int DEPTH = 16,
  parameter int W     = 41
) (
  input  logic                     aclk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  always_ff @(posedge aclk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Separate read register sees the pre-write contents on a same-address collision.
  always_ff @(posedge aclk) begin
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/rgb_led_sequencer.sv
// Plays a programmed table of RGB ctrl steps onto the blink-engine control lines.
module rgb_led_sequencer #(
  parameter int STEPS     = 16,
  parameter int LEN_WIDTH = 32
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       cfg_we,
  input  logic [$clog2(STEPS)-1:0]   cfg_addr,
  input  logic [LEN_WIDTH+8:0]       cfg_wdata,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop,
  input  logic [$clog2(STEPS)-1:0]   last_step,
  output logic                       mode_r,
  output logic                       mode_g,
  output logic                       mode_b,
  output logic                       enable_r,
  output logic                       enable_g,
  output logic                       enable_b,
  output logic                       holded_r,
  output logic                       holded_g,
  output logic                       holded_b,
  output logic                       busy,
  output logic [$clog2(STEPS)-1:0]   step_idx,
  output logic                       done
);
  import rgb_led_seq_pkg::*;

  localparam int IW = $clog2(STEPS);

  seq_state_t           r_state, w_state_nxt;
  logic [IW-1:0]        r_idx, w_idx_nxt;
  logic [LEN_WIDTH-1:0] r_cnt;
  seq_ctrl_t            r_ctrl;
  logic [LEN_WIDTH+8:0] w_rd_data;
  logic [LEN_WIDTH-1:0] w_len;
  seq_ctrl_t            w_rd_ctrl;
  logic [LEN_WIDTH-1:0] w_cnt_load;
  logic                 w_enter_run;

  // Read address follows the next index, so the step is in the read register during LOAD.
  rgb_led_seq_table #(.DEPTH(STEPS), .W(LEN_WIDTH + 9)) u_table (
    .aclk    (aclk),
    .i_we    (cfg_we),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_wdata),
    .i_raddr (w_idx_nxt),
    .o_rdata (w_rd_data)
  );

  assign w_len       = w_rd_data[LEN_WIDTH+8:9];
  assign w_rd_ctrl   = seq_ctrl_t'(w_rd_data[8:0]);
  assign w_cnt_load  = (w_len == '0) ? '0 : w_len - LEN_WIDTH'(1);
  assign w_enter_run = (r_state == LOAD) && (w_state_nxt == RUN);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE: if (start && !stop) begin
        w_state_nxt = LOAD;
        w_idx_nxt   = '0;
      end
      LOAD: w_state_nxt = RUN;
      RUN: if (r_cnt == '0) begin
        if (r_idx != last_step) begin
          w_state_nxt = LOAD;
          w_idx_nxt   = r_idx + IW'(1);
        end else if (loop) begin
          w_state_nxt = LOAD;
          w_idx_nxt   = '0;
        end else begin
          w_state_nxt = DONE;
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (stop && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset)                  r_cnt <= '0;
    else if (w_enter_run)        r_cnt <= w_cnt_load;
    else if (r_state == RUN && r_cnt != '0) r_cnt <= r_cnt - LEN_WIDTH'(1);
  end

  // Ctrl outputs change only on RUN entry or on leaving playback; LOAD holds them.
  always_ff @(posedge aclk) begin
    if (areset)                                            r_ctrl <= '0;
    else if (w_enter_run)                                  r_ctrl <= w_rd_ctrl;
    else if (w_state_nxt == IDLE || w_state_nxt == DONE)   r_ctrl <= '0;
  end

  assign mode_r   = r_ctrl.mode[CH_R];
  assign mode_g   = r_ctrl.mode[CH_G];
  assign mode_b   = r_ctrl.mode[CH_B];
  assign enable_r = r_ctrl.enable[CH_R];
  assign enable_g = r_ctrl.enable[CH_G];
  assign enable_b = r_ctrl.enable[CH_B];
  assign holded_r = r_ctrl.hold[CH_R];
  assign holded_g = r_ctrl.hold[CH_G];
  assign holded_b = r_ctrl.hold[CH_B];
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign step_idx = r_idx;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Directed bench for rgb_led_sequencer; snapshot = {busy, done, step_idx, mode, enable, hold}.
module tb_rgb_led_sequencer;

  logic        aclk = 1'b0;
  logic        areset, cfg_we, start, stop, loop;
  logic [3:0]  cfg_addr, last_step;
  logic [40:0] cfg_wdata;
  logic        mode_r, mode_g, mode_b, enable_r, enable_g, enable_b;
  logic        holded_r, holded_g, holded_b, busy, done;
  logic [3:0]  step_idx;
  logic [14:0] snap;
  logic [14:0] exp_s;
  int          errors = 0;
  int          checks = 0;

  always #5 aclk = ~aclk;

  rgb_led_sequencer #(.STEPS(16), .LEN_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .stop(stop), .loop(loop),
    .last_step(last_step), .mode_r(mode_r), .mode_g(mode_g), .mode_b(mode_b),
    .enable_r(enable_r), .enable_g(enable_g), .enable_b(enable_b),
    .holded_r(holded_r), .holded_g(holded_g), .holded_b(holded_b),
    .busy(busy), .step_idx(step_idx), .done(done)
  );

  assign snap = {busy, done, step_idx, mode_b, mode_g, mode_r,
                 enable_b, enable_g, enable_r, holded_b, holded_g, holded_r};

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] len,
                    input logic [2:0] m, input logic [2:0] e, input logic [2:0] h);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = {len, m, e, h};
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) tick();
    checks++;
    if (snap !== 15'd0) begin
      errors++; $display("FAIL reset_state: got %h want %h", snap, 15'd0);
    end
    areset = 1'b0;
    tick();
    checks++;
    if (snap !== 15'd0) begin
      errors++; $display("FAIL idle_after_reset: got %h want %h", snap, 15'd0);
    end
  endtask

  task automatic test_single_pass();
    wr(4'd0, 32'd4, 3'b000, 3'b001, 3'b000);
    wr(4'd1, 32'd2, 3'b010, 3'b110, 3'b000);
    last_step = 4'd1; loop = 1'b0;
    pulse_start();
    checks++;
    if (snap !== {1'b1, 1'b0, 4'd0, 9'd0}) begin
      errors++; $display("FAIL sp_load0: got %h want %h", snap, {1'b1, 1'b0, 4'd0, 9'd0});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_s = {1'b1, 1'b0, 4'd0, 3'b000, 3'b001, 3'b000};
      checks++;
      if (snap !== exp_s) begin
        errors++; $display("FAIL sp_run0 c%0d: got %h want %h", i, snap, exp_s);
      end
    end
    tick();
    exp_s = {1'b1, 1'b0, 4'd1, 3'b000, 3'b001, 3'b000};
    checks++;
    if (snap !== exp_s) begin
      errors++; $display("FAIL sp_load1: got %h want %h", snap, exp_s);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_s = {1'b1, 1'b0, 4'd1, 3'b010, 3'b110, 3'b000};
      checks++;
      if (snap !== exp_s) begin
        errors++; $display("FAIL sp_run1 c%0d: got %h want %h", i, snap, exp_s);
      end
    end
    tick();
    exp_s = {1'b1, 1'b1, 4'd1, 9'd0};
    checks++;
    if (snap !== exp_s) begin
      errors++; $display("FAIL sp_done: got %h want %h", snap, exp_s);
    end
    tick();
    checks++;
    if ({busy, done, snap[8:0]} !== 11'd0) begin
      errors++; $display("FAIL sp_idle: got %h want 0", {busy, done, snap[8:0]});
    end
  endtask

  task automatic test_loop();
    logic [3:0] ei;
    loop = 1'b1; last_step = 4'd1;
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      ei = ((k % 8) < 5) ? 4'd0 : 4'd1;
      checks++;
      if (step_idx !== ei || done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL loop_seq k=%0d: got idx=%0d done=%b busy=%b want idx=%0d done=0 busy=1",
                 k, step_idx, done, busy, ei);
      end
      tick();
    end
    stop = 1'b1; tick(); stop = 1'b0;
    checks++;
    if ({busy, done, snap[8:0]} !== 11'd0) begin
      errors++; $display("FAIL loop_stop: got %h want 0", {busy, done, snap[8:0]});
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL loop_no_done: got %b want 0", done);
    end
  endtask

  task automatic test_len0();
    wr(4'd0, 32'd0, 3'b000, 3'b111, 3'b000);
    last_step = 4'd0; loop = 1'b0;
    pulse_start();
    tick();
    exp_s = {1'b1, 1'b0, 4'd0, 3'b000, 3'b111, 3'b000};
    checks++;
    if (snap !== exp_s) begin
      errors++; $display("FAIL len0_run: got %h want %h", snap, exp_s);
    end
    tick();
    exp_s = {1'b1, 1'b1, 4'd0, 9'd0};
    checks++;
    if (snap !== exp_s) begin
      errors++; $display("FAIL len0_done: got %h want %h", snap, exp_s);
    end
    tick();
  endtask

  task automatic test_start_stop();
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL start_stop_idle: got busy=%b want 0", busy);
    end
    wr(4'd0, 32'd4, 3'b000, 3'b001, 3'b000);
    last_step = 4'd1; loop = 1'b1;
    pulse_start();
    repeat (6) tick();
    pulse_start();
    exp_s = {1'b1, 1'b0, 4'd1, 3'b010, 3'b110, 3'b000};
    checks++;
    if (snap !== exp_s) begin
      errors++; $display("FAIL start_while_busy: got %h want %h", snap, exp_s);
    end
    tick();
    checks++;
    if (step_idx !== 4'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL busy_wrap: got idx=%0d busy=%b want idx=0 busy=1", step_idx, busy);
    end
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_write_during_run();
    loop = 1'b0; last_step = 4'd1;
    pulse_start();
    tick();
    wr(4'd1, 32'd3, 3'b100, 3'b100, 3'b011);
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      exp_s = {1'b1, 1'b0, 4'd1, 3'b100, 3'b100, 3'b011};
      checks++;
      if (snap !== exp_s) begin
        errors++; $display("FAIL wr_run_new c%0d: got %h want %h", i, snap, exp_s);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL wr_run_done: got %b want 1", done);
    end
    tick();
  endtask

  task automatic test_write_in_load();
    pulse_start();
    repeat (5) tick();
    exp_s = {1'b1, 1'b0, 4'd1, 3'b000, 3'b001, 3'b000};
    checks++;
    if (snap !== exp_s) begin
      errors++; $display("FAIL load_hold: got %h want %h", snap, exp_s);
    end
    wr(4'd1, 32'd2, 3'b000, 3'b010, 3'b000);
    exp_s = {1'b1, 1'b0, 4'd1, 3'b100, 3'b100, 3'b011};
    checks++;
    if (snap !== exp_s) begin
      errors++; $display("FAIL wr_load_old: got %h want %h", snap, exp_s);
    end
    repeat (3) tick();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL wr_load_old_len: got done=%b want 1", done);
    end
    tick();
    pulse_start();
    repeat (6) tick();
    exp_s = {1'b1, 1'b0, 4'd1, 3'b000, 3'b010, 3'b000};
    checks++;
    if (snap !== exp_s) begin
      errors++; $display("FAIL wr_load_replay_new: got %h want %h", snap, exp_s);
    end
    repeat (2) tick();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL wr_load_replay_done: got done=%b want 1", done);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    wr(4'd0, 32'd1, 3'b000, 3'b001, 3'b000);
    wr(4'd1, 32'd1, 3'b000, 3'b010, 3'b000);
    wr(4'd2, 32'd1, 3'b000, 3'b100, 3'b000);
    wr(4'd3, 32'd5, 3'b000, 3'b111, 3'b101);
    last_step = 4'd3; loop = 1'b0;
    pulse_start();
    repeat (7) tick();
    exp_s = {1'b1, 1'b0, 4'd3, 3'b000, 3'b111, 3'b101};
    checks++;
    if (snap !== exp_s) begin
      errors++; $display("FAIL mid_run3: got %h want %h", snap, exp_s);
    end
    areset = 1'b1; tick(); areset = 1'b0;
    checks++;
    if (snap !== 15'd0) begin
      errors++; $display("FAIL mid_reset: got %h want %h", snap, 15'd0);
    end
    pulse_start();
    tick();
    exp_s = {1'b1, 1'b0, 4'd0, 3'b000, 3'b001, 3'b000};
    checks++;
    if (snap !== exp_s) begin
      errors++; $display("FAIL mid_replay: got %h want %h", snap, exp_s);
    end
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  initial begin
    areset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; last_step = '0;
    test_reset();
    test_single_pass();
    test_loop();
    test_len0();
    test_start_stop();
    test_write_during_run();
    test_write_in_load();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
